stack_engine: RTL
=================

# stack_engine

Game-state producer for the stacking display. Owns platform position, the packed 2-bit colour stack, and the single falling block, and updates them once per frame strobe. Its outputs drive the renderer's `pos_x`, `colors`, `fall_x`, `fall_y` and `fall_clr` inputs directly. All outputs are registered on `dclk`.

## Interface
- `FALL_STEP`, 2: pixels the block descends per `tick`.
- `MOVE_STEP`, 4: pixels the platform moves per `tick`.
- `TOLERANCE`, 50: maximum |fall_x − pos_x| that counts as a catch.
- `MAX_MISS`, 3: misses that end the game (1..15).
- `START_X`, 270: platform x after reset or restart.

Ports (name, direction, width, meaning):
- `dclk`  in  1  pixel/system clock; the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or restarts a game.
- `tick`  in  1  one-cycle frame strobe; all motion advances only on it.
- `btn_left`, `btn_right`  in  1 each  level inputs, already debounced.
- `pos_x`  out  10  platform left x.
- `colors`  out  32  packed stack: slot i (1..15) at bits [32−2i : 31−2i]; bits 31 and 0 are always 0.
- `fall_x`, `fall_y`  out  10 each  falling block top-left.
- `fall_clr`  out  2  falling block colour; 00 = no block shown.
- `height`  out  4  stacked layers (0..15).
- `misses`  out  4  missed blocks.
- `game_over`  out  1  high in OVER.

## Operation
- Colour codes: 00 empty, 01 green, 10 red, 11 blue. Geometry is fixed: block width 100, layer height 20, base top y = 400, screen bottom 480.
- Reset values: `pos_x`=START_X, `colors`=0, `fall_x`=0, `fall_y`=0, `fall_clr`=00, `height`=0, `misses`=0, `game_over`=0. State is IDLE.
- IDLE: holds all outputs. `start` → clear stack, height and misses, set `pos_x`=START_X → SPAWN. A `tick` in the same cycle as `start` is ignored.
- SPAWN (1 cycle): `fall_y`←0; load `fall_x` and `fall_clr` from the spawn source; spawn counter +1 → FALL.
- FALL, on `tick`:
  - Compute next = fall_y + FALL_STEP and landing line L = 400 − 20·height. Both are evaluated at 11 bits.
  - If next + 20 ≥ L and |fall_x − pos_x| ≤ TOLERANCE: `fall_y`←L−20 (snapped) → LAND.
  - Else if next ≥ 480: `misses`+1 and `fall_clr`←00. If the new misses equals MAX_MISS → OVER, else → SPAWN.
  - Else `fall_y`←next. A block that is not caught falls past the stack.
- LAND (1 cycle): write `fall_clr` into slot height+1; `height`+1; `fall_clr`←00. If the new height is 15 → OVER, else → SPAWN.
- OVER: `game_over`=1. All outputs are frozen and ticks are ignored. `start` restarts exactly as from IDLE and clears `game_over`.
- Platform motion, on `tick` in SPAWN, FALL and LAND only:
  - Left only: `pos_x`←max(pos_x−MOVE_STEP, 0).
  - Right only: `pos_x`←min(pos_x+MOVE_STEP, 540).
  - Both or neither: no change.
  - The catch test uses the pre-tick `pos_x`.

## Timing
- `start` → SPAWN next edge → `fall_clr` is valid 2 cycles after `start`.
- Catching `tick` → LAND state on the next edge. `colors` and `height` update 1 cycle after that, and a new block appears 1 cycle later still.
- `rst` clears all state immediately, independent of `dclk`, including mid-FALL and mid-LAND; no partial slot write survives.
- No output changes between ticks, except for SPAWN/LAND bookkeeping and `start`.

## Configuration
- `STACK_LFSR_EN` defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) steps every `dclk`.
  - Spawn `fall_x` = 140 + lfsr[7:0].
  - Spawn `fall_clr` = lfsr[9:8], with 00 mapped to 01.
- `STACK_LFSR_EN` undefined: deterministic spawn.
  - `fall_x` cycles 270, 230, 310, 190, indexed by spawn count mod 4 starting at 0.
  - `fall_clr` cycles 10, 01, 11, indexed by spawn count mod 3.
  - The LFSR is not built.

## Test plan
Deterministic mode, default parameters.
- Reset: pulse `rst` → `pos_x`=270, `colors`=0, `fall_clr`=00, `height`=0, `misses`=0, `game_over`=0.
- First catch: `start`, no buttons → block at x=270, clr 10. On tick 190, `fall_y`=380 → LAND. Then `colors`=32'h4000_0000, `height`=1, and the next spawn is x=230, clr 01.
- Saturation: hold `btn_left` 70 ticks → `pos_x` stops at 0. Hold `btn_right` 140 ticks → `pos_x` stops at 540. Both held → unchanged.
- Miss: hold `btn_right` until `pos_x`=540 before the block reaches y=380 → block passes to y≥480, `misses`=1, `fall_clr`=00 for 1 cycle. The third miss → `game_over`=1 and further ticks change nothing.
- Fill: steer under every block for 15 catches → `height`=15 and `game_over`=1. `colors` bits 31 and 0 are 0, and slots hold the 10,01,11 rotation.
- Async reset mid-FALL (`fall_y`=200): assert `rst` between edges → all outputs at reset values before the next `dclk` edge. A subsequent `start` behaves as in the first-catch scenario.

Source files
------------

// File: rtl/stack_if.sv
// Game-state bundle between the stack engine and its consumer (renderer plus input side).
// master = engine drives the game outputs; slave = consumer drives start/tick/buttons.
interface stack_if;
    logic        start;
    logic        tick;
    logic        btn_left;
    logic        btn_right;
    logic [9:0]  pos_x;
    logic [31:0] colors;
    logic [9:0]  fall_x;
    logic [9:0]  fall_y;
    logic [1:0]  fall_clr;
    logic [3:0]  height;
    logic [3:0]  misses;
    logic        game_over;

    modport master (
        input  start, tick, btn_left, btn_right,
        output pos_x, colors, fall_x, fall_y, fall_clr, height, misses, game_over
    );

    modport slave (
        output start, tick, btn_left, btn_right,
        input  pos_x, colors, fall_x, fall_y, fall_clr, height, misses, game_over
    );
endinterface

// File: rtl/stack_engine.sv
// Stacking-game state producer: platform, packed colour stack and one falling block, advanced per tick.
// Optional macro STACK_LFSR_EN selects LFSR-driven spawn instead of the fixed x/colour rotation.
module stack_engine #(
    parameter int FALL_STEP = 2,
    parameter int MOVE_STEP = 4,
    parameter int TOLERANCE = 50,
    parameter int MAX_MISS  = 3,
    parameter int START_X   = 270
) (
    input  logic dclk,
    input  logic rst,
    stack_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_LAND, S_OVER} state_t;

    state_t      state_reg, state_next;
    logic [9:0]  pos_x_reg, pos_x_next;
    logic [31:0] colors_reg, colors_next;
    logic [9:0]  fall_x_reg, fall_x_next;
    logic [9:0]  fall_y_reg, fall_y_next;
    logic [1:0]  fall_clr_reg, fall_clr_next;
    logic [3:0]  height_reg, height_next;
    logic [3:0]  misses_reg, misses_next;
    logic        game_over_reg, game_over_next;

    logic [9:0]  spawn_x;
    logic [1:0]  spawn_clr;

`ifdef STACK_LFSR_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) lfsr_reg <= 16'hACE1;
        else     lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end

    assign spawn_x   = 10'd140 + {2'b00, lfsr_reg[7:0]};
    assign spawn_clr = (lfsr_reg[9:8] == 2'b00) ? 2'b01 : lfsr_reg[9:8];
`else
    // Spawn count kept as two residues (mod 4 for x, mod 3 for colour).
    logic [1:0] x_idx_reg;
    logic [1:0] c_idx_reg;

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            x_idx_reg <= 2'd0;
            c_idx_reg <= 2'd0;
        end else if (state_reg == S_SPAWN) begin
            x_idx_reg <= x_idx_reg + 2'd1;
            c_idx_reg <= (c_idx_reg == 2'd2) ? 2'd0 : c_idx_reg + 2'd1;
        end
    end

    always_comb begin
        spawn_x = 10'd270;
        case (x_idx_reg)
            2'd0:    spawn_x = 10'd270;
            2'd1:    spawn_x = 10'd230;
            2'd2:    spawn_x = 10'd310;
            default: spawn_x = 10'd190;
        endcase
        spawn_clr = 2'b10;
        case (c_idx_reg)
            2'd0:    spawn_clr = 2'b10;
            2'd1:    spawn_clr = 2'b01;
            default: spawn_clr = 2'b11;
        endcase
    end
`endif

    // Platform position after this tick's buttons; the catch test still uses pos_x_reg.
    logic [9:0] pos_moved;
    always_comb begin
        pos_moved = pos_x_reg;
        if (bus.btn_left && !bus.btn_right)
            pos_moved = (pos_x_reg < 10'(MOVE_STEP)) ? 10'd0 : pos_x_reg - 10'(MOVE_STEP);
        else if (bus.btn_right && !bus.btn_left)
            pos_moved = (pos_x_reg > 10'(540 - MOVE_STEP)) ? 10'd540 : pos_x_reg + 10'(MOVE_STEP);
    end

    logic [10:0] next_y;
    logic [10:0] land_line;
    logic [9:0]  snap_y;
    logic [9:0]  x_diff;
    logic        catch_ok;
    logic [3:0]  misses_inc;

    assign next_y     = {1'b0, fall_y_reg} + 11'(FALL_STEP);
    assign land_line  = 11'd400 - 11'd20 * {7'd0, height_reg};
    assign snap_y     = 10'd380 - 10'd20 * {6'd0, height_reg};
    assign x_diff     = (fall_x_reg >= pos_x_reg) ? fall_x_reg - pos_x_reg : pos_x_reg - fall_x_reg;
    assign catch_ok   = (next_y + 11'd20 >= land_line) && (x_diff <= 10'(TOLERANCE));
    assign misses_inc = misses_reg + 4'd1;

    // Stack with the falling colour written into slot height+1.
    genvar gi;
    logic [31:0] colors_land;
    assign colors_land[31] = 1'b0;
    assign colors_land[0]  = 1'b0;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_slot
            assign colors_land[32-2*gi -: 2] =
                (height_reg == 4'(gi - 1)) ? fall_clr_reg : colors_reg[32-2*gi -: 2];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        pos_x_next     = pos_x_reg;
        colors_next    = colors_reg;
        fall_x_next    = fall_x_reg;
        fall_y_next    = fall_y_reg;
        fall_clr_next  = fall_clr_reg;
        height_next    = height_reg;
        misses_next    = misses_reg;
        game_over_next = game_over_reg;

        case (state_reg)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    colors_next    = 32'd0;
                    height_next    = 4'd0;
                    misses_next    = 4'd0;
                    pos_x_next     = 10'(START_X);
                    game_over_next = 1'b0;
                    state_next     = S_SPAWN;
                end
            end
            S_SPAWN: begin
                fall_y_next   = 10'd0;
                fall_x_next   = spawn_x;
                fall_clr_next = spawn_clr;
                if (bus.tick) pos_x_next = pos_moved;
                state_next = S_FALL;
            end
            S_FALL: begin
                if (bus.tick) begin
                    pos_x_next = pos_moved;
                    if (catch_ok) begin
                        fall_y_next = snap_y;
                        state_next  = S_LAND;
                    end else if (next_y >= 11'd480) begin
                        misses_next   = misses_inc;
                        fall_clr_next = 2'b00;
                        fall_y_next   = next_y[9:0];
                        if (misses_inc == 4'(MAX_MISS)) begin
                            game_over_next = 1'b1;
                            state_next     = S_OVER;
                        end else begin
                            state_next = S_SPAWN;
                        end
                    end else begin
                        fall_y_next = next_y[9:0];
                    end
                end
            end
            S_LAND: begin
                colors_next   = colors_land;
                height_next   = height_reg + 4'd1;
                fall_clr_next = 2'b00;
                if (bus.tick) pos_x_next = pos_moved;
                if (height_reg == 4'd14) begin
                    game_over_next = 1'b1;
                    state_next     = S_OVER;
                end else begin
                    state_next = S_SPAWN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            pos_x_reg     <= 10'(START_X);
            colors_reg    <= 32'd0;
            fall_x_reg    <= 10'd0;
            fall_y_reg    <= 10'd0;
            fall_clr_reg  <= 2'b00;
            height_reg    <= 4'd0;
            misses_reg    <= 4'd0;
            game_over_reg <= 1'b0;
        end else begin
            pos_x_reg     <= pos_x_next;
            colors_reg    <= colors_next;
            fall_x_reg    <= fall_x_next;
            fall_y_reg    <= fall_y_next;
            fall_clr_reg  <= fall_clr_next;
            height_reg    <= height_next;
            misses_reg    <= misses_next;
            game_over_reg <= game_over_next;
        end
    end

    assign bus.pos_x     = pos_x_reg;
    assign bus.colors    = colors_reg;
    assign bus.fall_x    = fall_x_reg;
    assign bus.fall_y    = fall_y_reg;
    assign bus.fall_clr  = fall_clr_reg;
    assign bus.height    = height_reg;
    assign bus.misses    = misses_reg;
    assign bus.game_over = game_over_reg;
endmodule
